// File: rtl/icache_bank_ctrl_responder_if.sv
// Request/acknowledge bus between the shared-icache control unit and one bank responder.
// The control unit is the master; each bank responder is a slave.
interface icache_bank_ctrl_responder_if;
    logic        ctrl_req_enable;
    logic        ctrl_ack_enable;
    logic        ctrl_req_disable;
    logic        ctrl_ack_disable;
    logic        ctrl_flush_req;
    logic        ctrl_flush_ack;
    logic        sel_flush_req;
    logic        sel_flush_ack;
    logic [31:0] sel_flush_addr;

    modport master (
        output ctrl_req_enable, ctrl_req_disable, ctrl_flush_req, sel_flush_req, sel_flush_addr,
        input  ctrl_ack_enable, ctrl_ack_disable, ctrl_flush_ack, sel_flush_ack
    );

    modport slave (
        input  ctrl_req_enable, ctrl_req_disable, ctrl_flush_req, sel_flush_req, sel_flush_addr,
        output ctrl_ack_enable, ctrl_ack_disable, ctrl_flush_ack, sel_flush_ack
    );
endinterface

// File: rtl/icache_bank_ctrl_responder.sv
// Per-bank control responder: serialises enable/disable/flush/selective-flush requests,
// drains the bank, invalidates tag lines and pulses one ack per request.
// Optional statistics counters are built when ICACHE_BANK_STAT_EN is defined.
module icache_bank_ctrl_responder #(
    parameter int unsigned NB_SETS    = 128,
    parameter int unsigned NB_WAYS    = 4,
    parameter int unsigned SET_ID_LSB = 4,
    localparam int unsigned SET_ID_WIDTH = $clog2(NB_SETS)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    icache_bank_ctrl_responder_if.slave ctrl,
    output logic                        cache_enabled_o,
    output logic                        fetch_block_o,
    input  logic                        bank_idle_i,
    output logic                        tag_req_o,
    output logic [SET_ID_WIDTH-1:0]     tag_addr_o,
    output logic [NB_WAYS-1:0]          tag_way_be_o,
    input  logic                        tag_gnt_i
`ifdef ICACHE_BANK_STAT_EN
    ,
    input  logic                        hit_i,
    input  logic                        miss_i,
    input  logic                        trans_i,
    input  logic                        ctrl_clear_regs_i,
    input  logic                        ctrl_enable_regs_i,
    output logic [31:0]                 ctrl_hit_count_o,
    output logic [31:0]                 ctrl_trans_count_o,
    output logic [31:0]                 ctrl_miss_count_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_WALK,
        S_SEL,
        S_ACK,
        S_WAIT_DROP
    } state_e;

    typedef enum logic [1:0] {
        R_ENABLE,
        R_DISABLE,
        R_FLUSH,
        R_SEL
    } req_e;

    // One extra bit so the counter never has to wrap at the last set.
    localparam logic [SET_ID_WIDTH:0] CNT_LAST = (SET_ID_WIDTH + 1)'(NB_SETS - 1);

    state_e                  state_q, state_d;
    req_e                    req_q, pick;
    logic                    pick_valid;
    logic                    served_req;
    logic                    last_grant;
    logic [SET_ID_WIDTH-1:0] set_q;
    logic [SET_ID_WIDTH:0]   cnt_q;
    logic                    enabled_q;

    // Priority among pending requests: disable > enable > flush > sel_flush.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pick_valid = 1'b1;
        pick       = R_DISABLE;
        if (ctrl.ctrl_req_disable)     pick = R_DISABLE;
        else if (ctrl.ctrl_req_enable) pick = R_ENABLE;
        else if (ctrl.ctrl_flush_req)  pick = R_FLUSH;
        else if (ctrl.sel_flush_req)   pick = R_SEL;
        else                           pick_valid = 1'b0;
    end

    always_comb begin
        served_req = 1'b0;
        unique case (req_q)
            R_ENABLE:  served_req = ctrl.ctrl_req_enable;
            R_DISABLE: served_req = ctrl.ctrl_req_disable;
            R_FLUSH:   served_req = ctrl.ctrl_flush_req;
            R_SEL:     served_req = ctrl.sel_flush_req;
            default:   served_req = 1'b0;
        endcase
    end

    assign last_grant = (cnt_q == CNT_LAST) && tag_gnt_i;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    if (pick == R_ENABLE && enabled_q) state_d = S_ACK;
                    else                               state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bank_idle_i) begin
                    unique case (req_q)
                        R_DISABLE: state_d = S_ACK;
                        R_SEL:     state_d = S_SEL;
                        default:   state_d = S_WALK;
                    endcase
                end
            end
            S_WALK:      if (last_grant) state_d = S_ACK;
            S_SEL:       if (tag_gnt_i)  state_d = S_ACK;
            S_ACK:       state_d = S_WAIT_DROP;
            S_WAIT_DROP: if (!served_req) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: req_q and set_q are only read after being loaded; they are reset anyway so
        // tag_addr_o never shows X out of reset.
        if (!rst_ni) begin
            req_q     <= R_ENABLE;
            set_q     <= '0;
            cnt_q     <= '0;
            enabled_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && pick_valid) begin
                req_q <= pick;
                set_q <= ctrl.sel_flush_addr[SET_ID_LSB +: SET_ID_WIDTH];
            end

            if (state_q == S_DRAIN)                 cnt_q <= '0;
            else if (state_q == S_WALK && tag_gnt_i) cnt_q <= cnt_q + 1'b1;

            if (state_q == S_DRAIN && bank_idle_i && req_q == R_DISABLE)
                enabled_q <= 1'b0;
            // An enable only turns lookups on once the whole array has been invalidated.
            if (state_q == S_WALK && last_grant && req_q == R_ENABLE)
                enabled_q <= 1'b1;
        end
    end

    always_comb begin
        fetch_block_o        = 1'b0;
        tag_req_o            = 1'b0;
        tag_addr_o           = set_q;
        tag_way_be_o         = '1;
        ctrl.ctrl_ack_enable  = 1'b0;
        ctrl.ctrl_ack_disable = 1'b0;
        ctrl.ctrl_flush_ack   = 1'b0;
        ctrl.sel_flush_ack    = 1'b0;
        unique case (state_q)
            S_DRAIN: fetch_block_o = 1'b1;
            S_WALK: begin
                fetch_block_o = 1'b1;
                tag_req_o     = 1'b1;
                tag_addr_o    = cnt_q[SET_ID_WIDTH-1:0];
            end
            S_SEL: begin
                fetch_block_o = 1'b1;
                tag_req_o     = 1'b1;
            end
            S_ACK: begin
                fetch_block_o         = 1'b1;
                ctrl.ctrl_ack_enable  = (req_q == R_ENABLE);
                ctrl.ctrl_ack_disable = (req_q == R_DISABLE);
                ctrl.ctrl_flush_ack   = (req_q == R_FLUSH);
                ctrl.sel_flush_ack    = (req_q == R_SEL);
            end
            default: ;
        endcase
    end

    assign cache_enabled_o = enabled_q;

`ifdef ICACHE_BANK_STAT_EN
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    // Clear wins over counting; each counter sticks at its maximum.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || ctrl_clear_regs_i) begin
            ctrl_hit_count_o   <= '0;
            ctrl_trans_count_o <= '0;
            ctrl_miss_count_o  <= '0;
        end else if (ctrl_enable_regs_i) begin
            if (hit_i && ctrl_hit_count_o != STAT_MAX)
                ctrl_hit_count_o <= ctrl_hit_count_o + 32'd1;
            if (trans_i && ctrl_trans_count_o != STAT_MAX)
                ctrl_trans_count_o <= ctrl_trans_count_o + 32'd1;
            if (miss_i && ctrl_miss_count_o != STAT_MAX)
                ctrl_miss_count_o <= ctrl_miss_count_o + 32'd1;
        end
    end
`endif

endmodule
